bcd_time_counter: RTL and testbench

Time-of-day counter for the digital clock, consuming the one-cycle tick produced by the clock divider. Advances seconds, minutes and hours in packed BCD on each tick and supports manual minute and hour setting. Its BCD outputs drive the seven-segment display multiplexer.

---
 rtl/clock_pkg.sv | 18 +
 rtl/bcd_mod_counter.sv | 43 ++++
 rtl/bcd_time_counter.sv | 64 ++++++
 tb/tb_bcd_time_counter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, field limits and the integer-to-BCD helper for the time-of-day counter.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Packs an integer 0-99 as two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [7:0] r;
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed BCD counter that wraps after MAX, with a combinational carry so that
// cascaded stages all advance in the same cycle.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int         MAX  = 59,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    localparam logic [7:0] MAX_BCD = to_bcd(MAX);

    bcd_digit_t tens, ones;
    logic       at_max;

    assign tens   = value[7:4];
    assign ones   = value[3:0];
    assign at_max = (value == MAX_BCD);
    assign carry  = en & at_max;

    // Wrapping on the full two-digit MAX, not on ones==9, is what makes hours stop at 23.
    always_ff @(posedge clk_in) begin
        if (reset)
            value <= INIT;
        else if (clr)
            value <= 8'h00;
        else if (en) begin
            if (at_max)
                value <= 8'h00;
            else if (ones == 4'd9)
                value <= {tens + 4'd1, 4'd0};
            else
                value <= {tens, ones + 4'd1};
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day counter: seconds/minutes/hours in packed BCD advanced by the divider tick,
// with level-sensitive set mode for manual minute and hour adjustment.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int INIT_HH = 12,
    parameter int INIT_MM = 0
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       day_wrap
);

    logic sec_en, min_en, hour_en;
    logic sec_carry, min_carry, hour_carry;

    // In set mode the pulses drive each field directly and the carry chain is cut.
    assign sec_en  = tick & ~set_mode;
    assign min_en  = set_mode ? inc_min  : sec_carry;
    assign hour_en = set_mode ? inc_hour : min_carry;

    bcd_mod_counter #(.MAX(SEC_MAX), .INIT(8'h00)) u_sec (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (sec_en),
        .clr    (set_mode),
        .value  (sec_bcd),
        .carry  (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX), .INIT(to_bcd(INIT_MM))) u_min (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (min_en),
        .clr    (1'b0),
        .value  (min_bcd),
        .carry  (min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX), .INIT(to_bcd(INIT_HH))) u_hour (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (hour_en),
        .clr    (1'b0),
        .value  (hour_bcd),
        .carry  (hour_carry)
    );

    // A manual 23->00 hour step is not a day rollover.
    always_ff @(posedge clk_in) begin
        if (reset)
            day_wrap <= 1'b0;
        else
            day_wrap <= hour_carry & ~set_mode;
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: a vector table plus hand-written multi-cycle sequences.
module tb_bcd_time_counter;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0, tick = 1'b0, set_mode = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;
    logic [7:0] sec_bcd, min_bcd, hour_bcd;
    logic       day_wrap;

    int checks   = 0;
    int failures = 0;

    bcd_time_counter dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .tick     (tick),
        .set_mode (set_mode),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .sec_bcd  (sec_bcd),
        .min_bcd  (min_bcd),
        .hour_bcd (hour_bcd),
        .day_wrap (day_wrap)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst, tck, set, im, ih;
        logic [7:0] hh, mm, ss;
        logic       dw;
        string      name;
    } vec_t;

    vec_t vecs[10];

    // Drive inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic t, input logic s, input logic im, input logic ih);
        reset = r; tick = t; set_mode = s; inc_min = im; inc_hour = ih;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] hh, input logic [7:0] mm,
                         input logic [7:0] ss, input logic dw);
        checks++;
        if (hour_bcd !== hh || min_bcd !== mm || sec_bcd !== ss || day_wrap !== dw) begin
            failures++;
            $display("FAIL %s: got %h:%h:%h wrap=%b, expected %h:%h:%h wrap=%b",
                     name, hour_bcd, min_bcd, sec_bcd, day_wrap, hh, mm, ss, dw);
        end
    endtask

    // From reset state 12:00, set mode to 23:59:00 (ends still in set mode).
    task automatic set_to_2359();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 1);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 1, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, "reset_default"};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 8'h00, 8'h01, 1'b0, "first_tick"};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, "enter_set_clears_sec"};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h01, 8'h00, 1'b0, "set_inc_min"};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 8'h02, 8'h00, 1'b0, "set_inc_both"};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h13, 8'h02, 8'h00, 1'b0, "run_rejects_inc"};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h13, 8'h02, 8'h01, 1'b0, "run_tick"};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h13, 8'h02, 8'h02, 1'b0, "back_to_back_tick"};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h13, 8'h02, 8'h00, 1'b0, "set_ignores_tick"};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, "reset_overrides"};

        @(posedge clk_in); #1;
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].tck, vecs[i].set, vecs[i].im, vecs[i].ih);
            check(vecs[i].name, vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].dw);
        end

        // Seconds rollover from 12:00:58.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 58; i++) step(0, 1, 0, 0, 0);
        check("reach_120058", 8'h12, 8'h00, 8'h58, 1'b0);
        step(0, 1, 0, 0, 0);
        check("sec_59", 8'h12, 8'h00, 8'h59, 1'b0);
        step(0, 1, 0, 0, 0);
        check("sec_rollover", 8'h12, 8'h01, 8'h00, 1'b0);

        // Full-day wrap, including a manual 23->00 hour step that must not pulse day_wrap.
        set_to_2359();
        check("set_2359", 8'h23, 8'h59, 8'h00, 1'b0);
        step(0, 0, 1, 0, 1);
        check("set_hour_wrap_no_daywrap", 8'h00, 8'h59, 8'h00, 1'b0);
        for (int i = 0; i < 23; i++) step(0, 0, 1, 0, 1);
        check("set_hour_back_23", 8'h23, 8'h59, 8'h00, 1'b0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0);
        check("reach_235959", 8'h23, 8'h59, 8'h59, 1'b0);
        step(0, 1, 0, 0, 0);
        check("day_wrap_pulse", 8'h00, 8'h00, 8'h00, 1'b1);
        step(0, 0, 0, 0, 0);
        check("day_wrap_drops", 8'h00, 8'h00, 8'h00, 1'b0);

        // Set-mode sequence from 10:59:37 (hour 12 + 22 steps = 10).
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) step(0, 0, 1, 0, 1);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 37; i++) step(0, 1, 0, 0, 0);
        check("reach_105937", 8'h10, 8'h59, 8'h37, 1'b0);
        step(0, 0, 1, 0, 0);
        check("set_clears_sec", 8'h10, 8'h59, 8'h00, 1'b0);
        step(0, 0, 1, 1, 0);
        check("set_min_wrap_no_carry", 8'h10, 8'h00, 8'h00, 1'b0);
        step(0, 0, 1, 1, 1);
        check("set_both_pulses", 8'h11, 8'h01, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        check("set_five_ticks_ignored", 8'h11, 8'h01, 8'h00, 1'b0);
        step(0, 1, 0, 0, 0);
        check("leave_set_tick_counts", 8'h11, 8'h01, 8'h01, 1'b0);

        // Reset colliding with the full cascade at 23:59:59.
        set_to_2359();
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0);
        check("reach_235959_again", 8'h23, 8'h59, 8'h59, 1'b0);
        step(1, 1, 0, 0, 0);
        check("reset_mid_cascade", 8'h12, 8'h00, 8'h00, 1'b0);
        step(0, 0, 0, 0, 0);
        check("no_late_daywrap", 8'h12, 8'h00, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
